// File: rtl/multi_clkdiv_pkg.sv
// Shared types for the multi-channel clock divider: controller states,
// per-channel configuration record and configuration helpers.
package multi_clkdiv_pkg;

  // Config fields are carried at a fixed width; CNT_WIDTH ports (1..32) zero-extend into it.
  localparam int CFG_W = 32;

  typedef enum logic [1:0] {
    STOP,
    ALIGN,
    RUN
  } state_e;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] phase;
    logic [CFG_W-1:0] high;
  } chan_cfg_t;

  function automatic chan_cfg_t default_cfg(input int div);
    chan_cfg_t c;
    c.div   = CFG_W'(div);
    c.phase = '0;
    c.high  = CFG_W'(div / 2);
    return c;
  endfunction

  function automatic logic cfg_illegal(input chan_cfg_t c);
    return (c.div < CFG_W'(2)) || (c.phase >= c.div) ||
           (c.high == '0) || (c.high >= c.div);
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: active config, period counter, registered outclk/tick.
// Outputs are registered from the counter's next value so they line up with it.
module clkdiv_channel
  import multi_clkdiv_pkg::*;
#(
  parameter int DEFAULT_DIV = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      capture,
  input  logic      load,
  input  logic      advance,
  input  chan_cfg_t cfg_in,
  output logic      outclk,
  output logic      tick
);

  localparam logic [CFG_W-1:0] ONE = CFG_W'(1);

  chan_cfg_t        active_reg;
  logic [CFG_W-1:0] cnt_reg;
  logic [CFG_W-1:0] cnt_next;
  logic             outclk_reg;
  logic             tick_reg;

  // load: leaving ALIGN, start at (div - phase) mod div; advance: staying in RUN.
  always_comb begin
    cnt_next = '0;
    if (load) begin
      cnt_next = (active_reg.phase == '0) ? '0 : active_reg.div - active_reg.phase;
    end else if (advance) begin
      cnt_next = (cnt_reg == active_reg.div - ONE) ? '0 : cnt_reg + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_reg <= default_cfg(DEFAULT_DIV);
      cnt_reg    <= '0;
      outclk_reg <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      if (capture) begin
        active_reg <= cfg_in;
      end
      cnt_reg    <= cnt_next;
      outclk_reg <= (load || advance) && (cnt_next < active_reg.high);
      tick_reg   <= (load || advance) && (cnt_next == '0);
    end
  end

  assign outclk = outclk_reg;
  assign tick   = tick_reg;

endmodule

// File: rtl/multi_clkdiv.sv
// Multi-channel programmable clock divider: STOP/ALIGN/RUN controller,
// validated config writes into per-channel shadow registers, lock tracking.
module multi_clkdiv
  import multi_clkdiv_pkg::*;
#(
  parameter int NUM_CLOCKS  = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                  refclk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [2:0]            cfg_chan,
  input  logic [CNT_WIDTH-1:0]  cfg_div,
  input  logic [CNT_WIDTH-1:0]  cfg_phase,
  input  logic [CNT_WIDTH-1:0]  cfg_high,
  output logic                  cfg_err,
  output logic [NUM_CLOCKS-1:0] outclk,
  output logic [NUM_CLOCKS-1:0] tick,
  output logic                  locked
);

  localparam int               LOCK_W   = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_ONE = LOCK_W'(1);
  localparam logic [3:0]        NUM_CH   = 4'(NUM_CLOCKS);

  state_e            state_reg;
  state_e            state_next;
  logic [LOCK_W-1:0] lock_cnt_reg;
  logic              cfg_err_reg;
  logic              accept;
  logic              bad;
  logic              wr_ok;
  chan_cfg_t         wr_cfg;

  always_comb begin
    wr_cfg.div   = CFG_W'(cfg_div);
    wr_cfg.phase = CFG_W'(cfg_phase);
    wr_cfg.high  = CFG_W'(cfg_high);
    cfg_ready    = (state_reg != ALIGN);
    accept       = cfg_valid && cfg_ready;
    bad          = cfg_illegal(wr_cfg) || ({1'b0, cfg_chan} >= NUM_CH);
    wr_ok        = accept && !bad;

    state_next = state_reg;
    case (state_reg)
      STOP:    if (enable) state_next = ALIGN;
      ALIGN:   state_next = RUN;
      RUN: begin
        if (!enable)    state_next = STOP;
        else if (wr_ok) state_next = ALIGN;
      end
      default: state_next = STOP;
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_reg    <= STOP;
      lock_cnt_reg <= '0;
      cfg_err_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cfg_err_reg <= accept && bad;
      if (state_reg == RUN) begin
        if (lock_cnt_reg != LOCK_MAX) lock_cnt_reg <= lock_cnt_reg + LOCK_ONE;
      end else begin
        lock_cnt_reg <= '0;
      end
    end
  end

  assign cfg_err = cfg_err_reg;
  assign locked  = (state_reg == RUN) && (lock_cnt_reg == LOCK_MAX);

  generate
    for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
      chan_cfg_t shadow_reg;
      chan_cfg_t shadow_next;

      // Channels capture the post-write shadow value so a write accepted on
      // the edge into ALIGN is the one that takes effect.
      assign shadow_next = (wr_ok && cfg_chan == 3'(gi)) ? wr_cfg : shadow_reg;

      always_ff @(posedge refclk) begin
        if (rst) shadow_reg <= default_cfg(DEFAULT_DIV);
        else     shadow_reg <= shadow_next;
      end

      clkdiv_channel #(
        .DEFAULT_DIV(DEFAULT_DIV)
      ) u_chan (
        .clk    (refclk),
        .rst    (rst),
        .capture(state_next == ALIGN),
        .load   (state_reg == ALIGN),
        .advance((state_reg == RUN) && (state_next == RUN)),
        .cfg_in (shadow_next),
        .outclk (outclk[gi]),
        .tick   (tick[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_clkdiv.sv
// Scoreboard bench for multi_clkdiv: the driver queues the expected outputs of
// each cycle, a negedge monitor pops and compares them.
module tb_multi_clkdiv;

  localparam int NC = 2;
  localparam int CW = 16;
  localparam int LC = 16;
  localparam int DD = 2;

  logic          refclk = 1'b0;
  logic          rst;
  logic          enable;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [2:0]    cfg_chan;
  logic [CW-1:0] cfg_div;
  logic [CW-1:0] cfg_phase;
  logic [CW-1:0] cfg_high;
  logic          cfg_err;
  logic [NC-1:0] outclk;
  logic [NC-1:0] tick;
  logic          locked;

  multi_clkdiv #(
    .NUM_CLOCKS(NC), .CNT_WIDTH(CW), .LOCK_CYCLES(LC), .DEFAULT_DIV(DD)
  ) dut (
    .refclk(refclk), .rst(rst), .enable(enable),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_chan(cfg_chan),
    .cfg_div(cfg_div), .cfg_phase(cfg_phase), .cfg_high(cfg_high),
    .cfg_err(cfg_err), .outclk(outclk), .tick(tick), .locked(locked)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [NC-1:0] outclk;
    logic [NC-1:0] tick;
    logic          locked;
    logic          cfg_err;
    logic          cfg_ready;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests = 0;
  int    fails = 0;

  // Config the bench expects to be active in each channel during RUN.
  int m_div[NC];
  int m_phase[NC];
  int m_high[NC];

  always @(negedge refclk) begin
    exp_t  e;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      tests++;
      if ({outclk, tick, locked, cfg_err, cfg_ready} !==
          {e.outclk, e.tick, e.locked, e.cfg_err, e.cfg_ready}) begin
        fails++;
        $display("FAIL %s: got outclk=%b tick=%b locked=%b cfg_err=%b cfg_ready=%b, expected outclk=%b tick=%b locked=%b cfg_err=%b cfg_ready=%b",
                 n, outclk, tick, locked, cfg_err, cfg_ready,
                 e.outclk, e.tick, e.locked, e.cfg_err, e.cfg_ready);
      end else begin
        $display("[TB] ok %s: outclk=%b tick=%b locked=%b cfg_err=%b",
                 n, outclk, tick, locked, cfg_err);
      end
    end
  end

  // Waveform of one channel in RUN cycle k: counter value (k + div - phase) mod div.
  function automatic logic [1:0] wave(input int ch, input int k);
    int c;
    c = (k + m_div[ch] - m_phase[ch]) % m_div[ch];
    return {(c < m_high[ch]), (c == 0)};
  endfunction

  task automatic step(input string name, input logic [NC-1:0] eo, input logic [NC-1:0] et,
                      input logic el, input logic ee, input logic er);
    exp_t e;
    @(posedge refclk);
    #1;
    e.outclk = eo; e.tick = et; e.locked = el; e.cfg_err = ee; e.cfg_ready = er;
    exp_q.push_back(e);
    name_q.push_back(name);
  endtask

  task automatic quiet(input string name, input logic er);
    step(name, '0, '0, 1'b0, 1'b0, er);
  endtask

  task automatic run(input string name, input int n, inout int k, input logic first_err);
    logic [NC-1:0] eo;
    logic [NC-1:0] et;
    logic [1:0]    w;
    for (int i = 0; i < n; i++) begin
      for (int ch = 0; ch < NC; ch++) begin
        w      = wave(ch, k);
        eo[ch] = w[1];
        et[ch] = w[0];
      end
      step($sformatf("%s k=%0d", name, k), eo, et, (k >= LC), (i == 0) && first_err, 1'b1);
      k++;
    end
  endtask

  task automatic set_cfg(input logic v, input int ch, input int d, input int p, input int h);
    cfg_valid = v;
    cfg_chan  = 3'(ch);
    cfg_div   = CW'(d);
    cfg_phase = CW'(p);
    cfg_high  = CW'(h);
  endtask

  task automatic set_model(input int ch, input int d, input int p, input int h);
    m_div[ch] = d; m_phase[ch] = p; m_high[ch] = h;
  endtask

  // A rejected write in RUN: err pulses one cycle later, waveform and lock continue.
  task automatic bad_write(input string name, input int ch, input int d, input int p,
                           input int h, inout int k);
    set_cfg(1'b1, ch, d, p, h);
    run(name, 1, k, 1'b1);
    set_cfg(1'b0, 0, 0, 0, 0);
    run({name, "_after"}, 2, k, 1'b0);
  endtask

  initial begin
    int k;
    rst = 1'b1; enable = 1'b0;
    set_cfg(1'b0, 0, 0, 0, 0);
    for (int ch = 0; ch < NC; ch++) set_model(ch, DD, 0, DD / 2);

    // Reset state
    quiet("reset0", 1'b1);
    quiet("reset1", 1'b1);
    rst = 1'b0;
    quiet("stop_idle", 1'b1);

    // Defaults: 1,0,1,0 on both channels from the first RUN cycle, lock after 16
    enable = 1'b1;
    quiet("align_dflt", 1'b0);
    k = 0;
    run("dflt", 20, k, 1'b0);

    // Reconfigure ch1 while locked: ALIGN cycle, new waveform, relock
    set_cfg(1'b1, 1, 3, 0, 1);
    quiet("reconf_align", 1'b0);
    set_cfg(1'b0, 0, 0, 0, 0);
    set_model(1, 3, 0, 1);
    k = 0;
    run("reconf", 20, k, 1'b0);

    // Rejected writes
    bad_write("bad_div1", 0, 1, 0, 1, k);
    bad_write("bad_phase4", 0, 4, 4, 1, k);
    bad_write("bad_chan3", 3, 4, 0, 2, k);

    // enable=0 with a valid write in RUN: straight to STOP, config kept
    enable = 1'b0;
    set_cfg(1'b1, 0, 4, 1, 3);
    quiet("stop_wr", 1'b1);
    set_cfg(1'b0, 0, 0, 0, 0);
    set_model(0, 4, 1, 3);
    quiet("stop_idle2", 1'b1);

    // Write in STOP: no state change
    set_cfg(1'b1, 1, 5, 2, 2);
    quiet("stop_wr_ch1", 1'b1);
    set_cfg(1'b0, 0, 0, 0, 0);
    set_model(1, 5, 2, 2);
    enable = 1'b1;
    quiet("align_new", 1'b0);
    k = 0;
    run("newcfg", 18, k, 1'b0);

    // Reset mid-RUN and mid-write: outputs zero, defaults back
    rst = 1'b1;
    set_cfg(1'b1, 0, 6, 0, 3);
    quiet("rst_mid", 1'b1);
    set_cfg(1'b0, 0, 0, 0, 0);
    quiet("rst_hold", 1'b1);
    rst = 1'b0;
    quiet("align_after_rst", 1'b0);
    for (int ch = 0; ch < NC; ch++) set_model(ch, DD, 0, DD / 2);
    k = 0;
    run("post_rst", 4, k, 1'b0);

    @(negedge refclk);
    #1;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    fails++;
    $display("FAIL watchdog: simulation still running at 100000, expected finish earlier");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multi_clkdiv.md
MULTI_CLKDIV -- requirements
Module: multi_clkdiv

Interface
REQ-001 The block SHALL have parameter NUM_CLOCKS, default 2, meaning the number of output channels (1..8).
REQ-002 The block SHALL have parameter CNT_WIDTH, default 16, meaning the width of the divide, phase and high-count fields.
REQ-003 The block SHALL have parameter LOCK_CYCLES, default 16, meaning the number of RUN cycles before locked asserts.
REQ-004 The block SHALL have parameter DEFAULT_DIV, default 2, meaning the reset divide ratio of every channel.
REQ-005 The block SHALL have port refclk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port enable, input, 1 bit: run request.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit: configuration write request.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: configuration write accept.
REQ-010 The block SHALL have port cfg_chan, input, 3 bits: target channel.
REQ-011 The block SHALL have ports cfg_div, cfg_phase and cfg_high, input, CNT_WIDTH bits each: divide ratio, phase offset in cycles, and high cycles per period.
REQ-012 The block SHALL have port cfg_err, output, 1 bit: one-cycle pulse flagging a rejected write.
REQ-013 The block SHALL have port outclk, output, NUM_CLOCKS bits: registered divided waveforms.
REQ-014 The block SHALL have port tick, output, NUM_CLOCKS bits: one-cycle pulse at the start of each period.
REQ-015 The block SHALL have port locked, output, 1 bit: all channels running and stable.

Function
REQ-016 The controller SHALL be a state machine with states STOP, ALIGN and RUN.
REQ-017 From STOP, enable=1 SHALL move to ALIGN; ALIGN SHALL always last exactly 1 cycle and then move to RUN.
REQ-018 In RUN, enable=0 SHALL move to STOP, otherwise an accepted cfg write SHALL move to ALIGN.
REQ-019 In STOP and ALIGN, outclk, tick and locked SHALL be 0.
REQ-020 Each channel i SHALL keep active registers div_i, phase_i and high_i, copied from its shadow registers in the ALIGN cycle.
REQ-021 In the first RUN cycle, counter c_i SHALL equal (div_i - phase_i) mod div_i.
REQ-022 In each later RUN cycle, c_i SHALL increment by 1 and wrap from div_i-1 to 0.
REQ-023 In RUN, outclk[i] SHALL be 1 exactly in cycles where c_i < high_i, and tick[i] SHALL be 1 exactly in cycles where c_i == 0.
REQ-024 A channel with phase 0 SHALL tick in the first RUN cycle; a channel with phase p SHALL first tick p cycles later.
REQ-025 A lock counter SHALL clear in ALIGN and increment each RUN cycle, saturating at LOCK_CYCLES; locked SHALL be 1 when it equals LOCK_CYCLES.
REQ-026 cfg_ready SHALL be 0 in ALIGN and 1 in STOP and RUN.
REQ-027 A write SHALL be accepted in the cycle where cfg_valid and cfg_ready are both 1.
REQ-028 An accepted write SHALL be rejected if cfg_div < 2, cfg_phase >= cfg_div, cfg_high == 0, cfg_high >= cfg_div, or cfg_chan >= NUM_CLOCKS.
REQ-029 A rejected write SHALL pulse cfg_err 1 cycle later, change no shadow register, and cause no state change.
REQ-030 A valid write SHALL update the shadow registers of that channel only; in STOP it SHALL cause no state change.
REQ-031 If a valid write and enable=0 occur in the same RUN cycle, the shadow registers SHALL update and the next state SHALL be STOP.
REQ-032 locked SHALL drop to 0 in the cycle after a reconfiguration write or enable deassertion is accepted.

Reset
REQ-033 While rst=1, the state SHALL be STOP and all counters SHALL be 0.
REQ-034 While rst=1, outclk, tick, locked and cfg_err SHALL be 0.
REQ-035 While rst=1, every shadow and active register SHALL be set to div=DEFAULT_DIV, phase=0 and high=DEFAULT_DIV/2.
REQ-036 rst SHALL override every other input, including in mid-operation and mid-write.

Structure
REQ-037 A shared package SHALL hold the state enum (STOP/ALIGN/RUN) and the per-channel config record typedef (div, phase, high).
REQ-038 The channel counter, outclk and tick generation SHALL be implemented in one sub-module, clkdiv_channel, instantiated NUM_CLOCKS times by generate.

Verification
REQ-039 The bench SHALL cover: reset, then enable=1 with defaults -> outclk[0] and outclk[1] equal 1,0,1,0,... starting in the first RUN cycle, and locked=1 after 16 RUN cycles.
REQ-040 The bench SHALL cover: write ch1 div=5, phase=2, high=2 in STOP, then enable -> tick[1] in RUN cycles 2, 7 and 12, and outclk[1] high in cycles 2-3, 7-8, ...
REQ-041 The bench SHALL cover: a write during RUN with locked=1 -> locked=0 the next cycle, 1 ALIGN cycle with outputs 0, new waveform, then relock after 16 cycles.
REQ-042 The bench SHALL cover: writes with div=1, with phase=4 and div=4, and with cfg_chan=3 -> cfg_err pulses each time, with waveforms and state unchanged.
REQ-043 The bench SHALL cover: enable=0 together with a valid write in RUN -> STOP next cycle, and the new config is applied on the next enable.
REQ-044 The bench SHALL cover: rst=1 mid-RUN -> all outputs 0 and defaults restored on the next edge.
